// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decoder signal bundle for the fetch stage
interface fetch_unit_if;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        pc_inc;
    logic        pc_ie;
    logic [15:0] pc_in;

    // master: the fetch unit; slave: instruction memory plus decoder
    modport master (
        output imem_addr, imem_req, instr, imm, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, pc_inc, pc_ie, pc_in
    );

    modport slave (
        input  imem_addr, imem_req, instr, imm, instr_pc, instr_valid,
        output imem_ack, imem_rdata, pc_inc, pc_ie, pc_in
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem reads and prefetch FIFO feeding the decoder
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_next;
    logic [15:0]   fetch_pc, fetch_pc_next;
    logic          req, req_next;
    logic [15:0]   addr, addr_next;
    logic [47:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          valid, redirect, pop, push, room;

    assign valid    = (count != '0);
    assign redirect = valid && bus.pc_ie;
    assign pop      = valid && bus.pc_inc && !bus.pc_ie;
    assign push     = (state == WAIT) && bus.imem_ack && !redirect;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect)
            fetch_pc_next = bus.pc_in;
        else if (push)
            fetch_pc_next = fetch_pc + 16'd1;
    end

    // the in-flight word has a reserved slot, so issue only while the post-edge FIFO has room
    assign room = (count_next < FULL);

    always_comb begin
        state_next = state;
        req_next   = req;
        addr_next  = addr;
        case (state)
            IDLE: begin
                if (room) begin
                    state_next = WAIT;
                    req_next   = 1'b1;
                    addr_next  = fetch_pc_next;
                end
            end
            WAIT, DROP: begin
                if (bus.imem_ack) begin
                    if (room) begin
                        state_next = WAIT;
                        req_next   = 1'b1;
                        addr_next  = fetch_pc_next;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            addr     <= RESET_PC;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            req      <= req_next;
            addr     <= addr_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // entry layout: {pc, immediate, opcode}
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= {addr, bus.imem_rdata};
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? mem[rd_ptr][15:0]  : 16'h0000;
    assign bus.imm         = valid ? mem[rd_ptr][31:16] : 16'h0000;
    assign bus.instr_pc    = valid ? mem[rd_ptr][47:32] : 16'h0000;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue-level model
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] salt = 16'h0000;

    // memory image: opcode word derived from the address, immediate = address + 0x100
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a + 16'h0100, a ^ salt};
    endfunction

    // reference model: buffered pcs, expected request state and next sequential fetch
    logic [15:0] q[$];
    bit          exp_req;
    logic [15:0] exp_addr;
    bit          wanted;
    logic [15:0] next_fetch;

    // stimulus knobs
    bit          inc_en;
    bit          ie_now;
    logic [15:0] target;
    int          lat_min, lat_max;
    bit          stray_ack;
    int          age, lat;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [15:0] h;
        logic [31:0] w;
        bit          valid, redir, pop, ack;
        check("req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req)
            check("addr", 32'(bus.imem_addr), 32'(exp_addr));
        valid = (q.size() != 0);
        check("valid", 32'(bus.instr_valid), 32'(valid));
        if (valid) begin
            h = q[0];
            w = mem_word(h);
            check("instr_pc", 32'(bus.instr_pc), 32'(h));
            check("instr", 32'(bus.instr), 32'(w[15:0]));
            check("imm", 32'(bus.imm), 32'(w[31:16]));
        end else begin
            check("instr_zero", 32'(bus.instr), 32'h0);
            check("imm_zero", 32'(bus.imm), 32'h0);
        end
        ack = 1'b0;
        if (bus.imem_req) begin
            if (age == 0)
                lat = int'($urandom_range(lat_max, lat_min));
            age++;
            if (age >= lat) begin
                ack = 1'b1;
                age = 0;
            end
        end else begin
            age = 0;
            if (stray_ack)
                ack = 1'b1;
        end
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
        bus.pc_inc     = inc_en;
        bus.pc_ie      = ie_now;
        bus.pc_in      = target;
        redir = valid && ie_now;
        pop   = valid && inc_en && !ie_now;
        ack   = ack && exp_req;
        if (pop)
            void'(q.pop_front());
        if (ack && wanted && !redir) begin
            q.push_back(exp_addr);
            next_fetch = exp_addr + 16'd1;
        end
        if (redir) begin
            q.delete();
            next_fetch = target;
            wanted     = 1'b0;
        end
        if (ack)
            exp_req = 1'b0;
        if (!exp_req && q.size() < DEPTH) begin
            exp_req  = 1'b1;
            exp_addr = next_fetch;
            wanted   = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.pc_inc     = 1'b0;
        bus.pc_ie      = 1'b0;
        bus.pc_in      = 16'h0;
        @(posedge clk);
        #1;
        q.delete();
        exp_req    = 1'b0;
        wanted     = 1'b0;
        next_fetch = RESET_PC;
        exp_addr   = RESET_PC;
        age        = 0;
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr", 32'(bus.instr), 32'h0);
        check("rst_imm", 32'(bus.imm), 32'h0);
        check("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.instr_valid && n < 50) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, 32'(bus.instr_valid), 32'h1);
    endtask

    initial begin
        int first_valid;
        int n;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.pc_inc     = 1'b0;
        bus.pc_ie      = 1'b0;
        bus.pc_in      = 16'h0;
        stray_ack = 1'b0;
        ie_now    = 1'b0;
        target    = 16'h0;

        // streaming fetch, single-cycle memory, decoder always retiring
        lat_min = 1; lat_max = 1; inc_en = 1'b1;
        do_reset();
        first_valid = -1;
        repeat (12) begin
            if (bus.instr_valid && first_valid < 0)
                first_valid = cyc;
            cycle();
        end
        check("s1_first_valid_cycle", 32'(first_valid), 32'd2);
        check("s1_instr_pc", 32'(bus.instr_pc), 32'd10);
        check("s1_imm", 32'(bus.imm), 32'h010A);
        check("s1_imem_addr", 32'(bus.imem_addr), 32'd11);

        // decoder stall fills the FIFO and parks the request
        inc_en = 1'b0;
        do_reset();
        repeat (6) cycle();
        check("s2_req_low", 32'(bus.imem_req), 32'h0);
        check("s2_valid", 32'(bus.instr_valid), 32'h1);
        check("s2_instr", 32'(bus.instr), 32'h0000);
        inc_en = 1'b1;
        cycle();
        check("s2_resume_req", 32'(bus.imem_req), 32'h1);
        check("s2_resume_addr", 32'(bus.imem_addr), 32'd2);

        // redirect while the request to addr 1 is still waiting on a 3-cycle memory
        lat_min = 3; lat_max = 3; inc_en = 1'b0;
        do_reset();
        repeat (5) cycle();
        check("s3_pending_addr", 32'(bus.imem_addr), 32'd1);
        ie_now = 1'b1; target = 16'h0040;
        cycle();
        ie_now = 1'b0;
        check("s3_flushed", 32'(bus.instr_valid), 32'h0);
        cycle();
        check("s3_new_addr", 32'(bus.imem_addr), 32'h0040);
        wait_valid("s3");
        check("s3_instr_pc", 32'(bus.instr_pc), 32'h0040);

        // redirect wins over a simultaneous retire
        lat_min = 1; lat_max = 1; inc_en = 1'b1;
        do_reset();
        n = 0;
        while (!(bus.instr_valid && bus.instr_pc == 16'd5) && n < 50) begin
            cycle();
            n++;
        end
        check("s4_reach_pc5", 32'(bus.instr_pc), 32'd5);
        ie_now = 1'b1; target = 16'h0010;
        cycle();
        ie_now = 1'b0;
        wait_valid("s4");
        check("s4_instr_pc", 32'(bus.instr_pc), 32'h0010);

        // address wrap at the top of memory
        ie_now = 1'b1; target = 16'hFFFF;
        cycle();
        ie_now = 1'b0;
        wait_valid("s5a");
        check("s5_pc_ffff", 32'(bus.instr_pc), 32'hFFFF);
        cycle();
        wait_valid("s5b");
        check("s5_pc_wrap", 32'(bus.instr_pc), 32'h0000);

        // reset during an outstanding request, late ack must be ignored
        lat_min = 5; lat_max = 5; inc_en = 1'b1;
        do_reset();
        cycle();
        cycle();
        do_reset();
        stray_ack = 1'b1;
        cycle();
        stray_ack = 1'b0;
        check("s6_valid", 32'(bus.instr_valid), 32'h0);
        check("s6_req", 32'(bus.imem_req), 32'h1);
        check("s6_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        repeat (4) cycle();
        check("s6_still_empty", 32'(bus.instr_valid), 32'h0);
        cycle();
        check("s6_valid_after_ack", 32'(bus.instr_valid), 32'h1);
        check("s6_instr_pc", 32'(bus.instr_pc), 32'(RESET_PC));

        // randomized traffic
        salt    = 16'($urandom);
        lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            inc_en    = ($urandom_range(0, 9) < 7);
            ie_now    = ($urandom_range(0, 19) == 0);
            target    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            stray_ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                cycle();
        end
        stray_ack = 1'b0;
        ie_now    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the core decoder.
- Maintains the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned 32-bit words in a small prefetch FIFO; each word is 16-bit opcode word + 16-bit immediate.
- Presents the head entry to the decoder and obeys the decoder's pc_inc/pc_ie controls, flushing on redirect.

Parameters:
- DEPTH, 2: prefetch FIFO entries; power of 2, >=2.
- RESET_PC, 16'h0000: first fetch address after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_addr  out  16  instruction word address
- imem_req  out  1  read request
- imem_ack  in  1  one-cycle response strobe; data valid same cycle
- imem_rdata  in  32  [15:0] opcode word, [31:16] immediate
- instr  out  16  head opcode word to decoder; 16'h0000 when !instr_valid
- imm  out  16  head immediate; 16'h0000 when !instr_valid
- instr_pc  out  16  address of head instruction, used as link value
- instr_valid  out  1  head entry present
- pc_inc  in  1  decoder: retire head, advance sequentially
- pc_ie  in  1  decoder: redirect to pc_in
- pc_in  in  16  redirect target from ALU

Behaviour:
- Reset: applied at clk when rst=1.
  - imem_req=0, imem_addr=RESET_PC, FIFO empty, instr_valid=0, instr/imm/instr_pc=0.
  - fetch_pc=RESET_PC; state=IDLE; any pending request is abandoned.
  - An imem_ack arriving while no request is outstanding is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data wanted.
  - DROP: request outstanding, data to be discarded.
- IDLE -> WAIT:
  - Fires when (fifo_count < DEPTH), evaluated after this cycle's pop.
  - imem_req=1 and imem_addr=fetch_pc, registered; request visible the cycle after the decision.
  - First request is visible in the first cycle after rst deasserts.
- Request hold: while in WAIT or DROP, imem_req and imem_addr are held stable until imem_ack. At most one request is outstanding.
- WAIT + imem_ack:
  - Push {imem_rdata, imem_addr} into the FIFO; fetch_pc += 1, wrapping 16'hFFFF -> 16'h0000.
  - Next state is WAIT with a new address if space remains after this cycle's push/pop, else IDLE with imem_req=0.
  - Back-to-back requests are allowed; imem_req may stay high across acks with a changing address.
- Head output: instr_valid = (fifo_count != 0). instr, imm and instr_pc come from the FIFO head, combinationally from registered storage. No bypass: an ack at cycle N makes the word visible at N+1 at the earliest.
- Retire: pc_inc=1 && pc_ie=0 && instr_valid=1 at a clk edge pops the head. pc_inc/pc_ie are ignored while instr_valid=0, because the decoder treats opcode 0 as nop with pc_inc=1.
- Stall: instr_valid=1 with pc_inc=0 and pc_ie=0 holds the head unchanged for any number of cycles (memory-stall case).
- Redirect: pc_ie=1 && instr_valid=1 at an edge:
  - Flush the FIFO (count=0); fetch_pc=pc_in.
  - pc_ie has priority over a simultaneous pc_inc.
  - Same edge, IDLE: next request to pc_in is issued and visible next cycle.
  - Same edge, WAIT with no ack this cycle: go to DROP.
  - Same edge, WAIT with ack this cycle: discard the data (not pushed; fetch_pc is still pc_in) and issue the new request.
- DROP + imem_ack: data discarded, then request pc_in. A further redirect while in DROP just overwrites fetch_pc.
- Simultaneous push and pop: both take effect; count unchanged. A push is permitted into a full FIFO only if a pop happens the same edge. Issue logic never exceeds DEPTH entries including the in-flight word.
- FIFO uses wrap-around read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.

Test Plan:
- Reset then imem acking every cycle with rdata={addr+16'h100, addr}, decoder pc_inc=1 always:
  - imem_addr sequence 0,1,2,...
  - instr_valid first high 2 cycles after rst deasserts.
  - instr=0,1,2,... with instr_pc equal to instr; imm=instr+16'h100.
- Same stimulus with pc_inc=0 for 6 cycles:
  - FIFO fills to 2 entries, then imem_req=0.
  - instr holds 0x0000 with instr_valid=1.
  - Releasing pc_inc resumes fetching at address 2.
- Ack latency 3 cycles, assert pc_ie with pc_in=16'h0040 one cycle after the request to addr 1 is issued:
  - Next cycle instr_valid=0.
  - Data for addr 1 is dropped; the next imem_addr is 0x0040.
  - Next valid instr_pc=0x0040.
- pc_ie=1 and pc_inc=1 together at head instr_pc=5, pc_in=16'h0010 -> redirect wins; next presented instr_pc=0x0010, not 6.
- Redirect to 16'hFFFF with sequential execution -> fetch addresses FFFF then 0000; instr_pc wraps to 0000.
- Assert rst while in WAIT, then ack arrives the cycle after rst deasserts -> ack ignored; fresh request to RESET_PC; instr_valid stays 0 until that request's ack.
